// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transfer sequencer slice.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    CAPTURE = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_byte_fifo.sv
// Single-clock byte FIFO with explicit occupancy count; pointers wrap modulo DEPTH.
module spi_byte_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic [SPI_BYTE_W-1:0]   wdata_i,
  input  logic                    pop_i,
  output logic [SPI_BYTE_W-1:0]   rdata_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [SPI_BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_en, pop_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Streams FIFO-buffered bytes through a free-running SPI master, one t_start per byte,
// and returns each received byte through a valid/ready slot with per-phase timeout.
module spi_xfer_sequencer
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 11
) (
  input  logic                    sys_clk,
  input  logic                    rstn,
  input  logic [SPI_BYTE_W-1:0]   tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [SPI_BYTE_W-1:0]   rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    spi_t_start,
  output logic [SPI_BYTE_W-1:0]   spi_d_in,
  input  logic [SPI_BYTE_W-1:0]   spi_d_out,
  input  logic                    spi_cs,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  tx_level,
  output logic                    timeout_err,
  input  logic                    err_clr
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  spi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SPI_BYTE_W-1:0] d_in_q, d_in_d;
  logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  t_start_q, t_start_d;
  logic                  err_q, err_d;

  logic [SPI_BYTE_W-1:0] fifo_rdata;
  logic                  fifo_full, fifo_empty, pop;

  spi_byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (rstn),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (tx_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tx_ready    = ~fifo_full;
  assign busy        = (state_q != IDLE);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign spi_t_start = t_start_q;
  assign spi_d_in    = d_in_q;
  assign timeout_err = err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_in_d     = d_in_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    t_start_d  = 1'b0;
    err_d      = err_q & ~err_clr;
    pop        = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    // The awaited cs level takes priority over an expiring count in the same cycle.
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && !rx_valid_q && spi_cs) begin
          pop       = 1'b1;
          d_in_d    = fifo_rdata;
          t_start_d = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!spi_cs) begin
          cnt_d   = '0;
          state_d = WAIT_HI;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (spi_cs) begin
          state_d = CAPTURE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: begin
        rx_data_d  = spi_d_out;
        rx_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      d_in_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      t_start_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_in_q     <= d_in_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      t_start_q  <= t_start_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a hand-driven SPI master model.
module tb_spi_xfer_sequencer;

  logic       sys_clk = 1'b0;
  logic       rstn    = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       spi_t_start;
  logic [7:0] spi_d_in;
  logic [7:0] spi_d_out = '0;
  logic       spi_cs = 1'b1;
  logic       busy;
  logic [3:0] tx_level;
  logic       timeout_err;
  logic       err_clr = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  spi_xfer_sequencer #(
    .DEPTH(8),
    .TIMEOUT_CYC(16),
    .CNT_W(5)
  ) dut (
    .sys_clk     (sys_clk),
    .rstn        (rstn),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .spi_t_start (spi_t_start),
    .spi_d_in    (spi_d_in),
    .spi_d_out   (spi_d_out),
    .spi_cs      (spi_cs),
    .busy        (busy),
    .tx_level    (tx_level),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_level"},  32'(tx_level),    32'h0);
    chk({tag, "_ready"},  32'(tx_ready),    32'h1);
    chk({tag, "_rxv"},    32'(rx_valid),    32'h0);
    chk({tag, "_rxd"},    32'(rx_data),     32'h0);
    chk({tag, "_tstart"}, 32'(spi_t_start), 32'h0);
    chk({tag, "_din"},    32'(spi_d_in),    32'h0);
    chk({tag, "_busy"},   32'(busy),        32'h0);
    chk({tag, "_err"},    32'(timeout_err), 32'h0);
  endtask

  // Entered one cycle after t_start: drives cs low for nlow edges, then high with dout.
  task automatic xfer(input logic [7:0] dout, input int nlow);
    tick();
    chk("xfer_waitlo_busy", 32'(busy), 32'h1);
    chk("xfer_tstart_gone", 32'(spi_t_start), 32'h0);
    spi_cs = 1'b0;
    repeat (nlow) tick();
    spi_cs    = 1'b1;
    spi_d_out = dout;
    tick();
    chk("xfer_rxv_not_yet", 32'(rx_valid), 32'h0);
    tick();
    chk("xfer_rxv",  32'(rx_valid), 32'h1);
    chk("xfer_rxd",  32'(rx_data),  32'(dout));
    chk("xfer_idle", 32'(busy),     32'h0);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("consume_rxv", 32'(rx_valid), 32'h0);
  endtask

  initial begin
    #2 rstn = 1'b0;
    #2 chk_reset("rst0");
    tick();
    rstn = 1'b1;
    tick();

    // Single byte: accepted on one edge, launched on the next.
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("s1_level", 32'(tx_level), 32'h1);
    chk("s1_no_tstart", 32'(spi_t_start), 32'h0);
    tick();
    chk("s1_tstart", 32'(spi_t_start), 32'h1);
    chk("s1_din",    32'(spi_d_in),    32'hA5);
    chk("s1_popped", 32'(tx_level),    32'h0);
    xfer(8'h3C, 8);
    chk("s1_din_held", 32'(spi_d_in), 32'hA5);

    // Backpressure: occupied RX slot blocks the next start.
    tx_data = 8'h11; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (3) tick();
    chk("bp_no_tstart", 32'(spi_t_start), 32'h0);
    chk("bp_idle",      32'(busy),        32'h0);
    chk("bp_level",     32'(tx_level),    32'h1);
    consume();
    chk("bp_no_tstart2", 32'(spi_t_start), 32'h0);
    tick();
    chk("bp_tstart", 32'(spi_t_start), 32'h1);
    chk("bp_din",    32'(spi_d_in),    32'h11);
    xfer(8'h77, 3);
    consume();

    // Timeout in WAIT_LO: cs never falls.
    tx_data = 8'h22; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    chk("to_tstart", 32'(spi_t_start), 32'h1);
    tick();
    repeat (15) tick();
    chk("to_not_yet_err",  32'(timeout_err), 32'h0);
    chk("to_not_yet_busy", 32'(busy),        32'h1);
    tick();
    chk("to_err",  32'(timeout_err), 32'h1);
    chk("to_idle", 32'(busy),        32'h0);
    chk("to_rxv",  32'(rx_valid),    32'h0);
    tick();
    chk("to_err_sticky", 32'(timeout_err), 32'h1);
    chk("to_rxv2",       32'(rx_valid),    32'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_clr", 32'(timeout_err), 32'h0);

    // Burst into a stalled master until full.
    for (int i = 1; i <= 9; i++) begin
      tx_data = 8'(i); tx_valid = 1'b1;
      tick();
    end
    tx_data = 8'h0A;
    chk("full_level", 32'(tx_level), 32'h8);
    chk("full_ready", 32'(tx_ready), 32'h0);
    chk("full_din",   32'(spi_d_in), 32'h01);
    tick();
    tx_valid = 1'b0;
    chk("full_held", 32'(tx_level), 32'h8);

    // Asynchronous reset while in WAIT_HI.
    spi_cs = 1'b0;
    tick();
    tick();
    chk("mid_busy", 32'(busy), 32'h1);
    #2 rstn = 1'b0;
    #1 chk_reset("rst_mid");
    spi_cs = 1'b1;
    tick();
    rstn = 1'b1;
    repeat (4) tick();
    chk("post_rst_tstart", 32'(spi_t_start), 32'h0);
    chk("post_rst_busy",   32'(busy),        32'h0);
    chk("post_rst_level",  32'(tx_level),    32'h0);

    // Queue three while cs is low, then push during the IDLE->START cycle.
    spi_cs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_data = 8'h31 + 8'(i); tx_valid = 1'b1;
      tick();
    end
    chk("pp_level3", 32'(tx_level), 32'h3);
    chk("pp_idle",   32'(busy),     32'h0);
    spi_cs  = 1'b1;
    tx_data = 8'h34;
    tick();
    tx_valid = 1'b0;
    chk("pp_level_same", 32'(tx_level),    32'h3);
    chk("pp_tstart",     32'(spi_t_start), 32'h1);
    chk("pp_din31",      32'(spi_d_in),    32'h31);
    xfer(8'hC1, 3);
    consume();
    tick();
    chk("pp_din32",   32'(spi_d_in), 32'h32);
    chk("pp_level2",  32'(tx_level), 32'h2);
    xfer(8'hC2, 3);
    consume();
    tick();
    chk("pp_din33",   32'(spi_d_in), 32'h33);
    chk("pp_level1",  32'(tx_level), 32'h1);
    xfer(8'hC3, 3);
    consume();
    tick();
    chk("pp_din34",   32'(spi_d_in), 32'h34);
    chk("pp_level0",  32'(tx_level), 32'h0);
    xfer(8'hC4, 3);
    consume();
    repeat (2) tick();
    chk("end_idle",   32'(busy),        32'h0);
    chk("end_no_err", 32'(timeout_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
